// File: rtl/p1_multisum.sv
// Sum-of-multiples engine: adds every n in [1, limit) divisible by any of NDIV run-time divisors,
// one n per clock, using per-divisor residue counters instead of dividers.
module p1_multisum #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NDIV  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      limit,
  input  logic [NDIV*CNT_W-1:0] div,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      sum,
  output logic                  overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        limit_q, limit_d;
  logic [NDIV*CNT_W-1:0]   div_q, div_d;
  logic [NDIV*CNT_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]        n_q, n_d;
  logic [WIDTH-1:0]        sum_q, sum_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, done_q;
  logic                    match;
  logic [WIDTH:0]          add_full;

  always_comb begin
    state_d  = state_q;
    limit_d  = limit_q;
    div_d    = div_q;
    res_d    = res_q;
    n_d      = n_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    match    = 1'b0;
    add_full = {1'b0, sum_q} + (WIDTH + 1)'(n_q);

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          limit_d = limit;
          div_d   = div;
          n_d     = CntOne;
          sum_d   = '0;
          ovf_d   = 1'b0;
          // Residue tracks n mod d; n starts at 1, so it is 0 only when d is 1.
          for (int i = 0; i < NDIV; i++) begin
            res_d[i*CNT_W +: CNT_W] = (div[i*CNT_W +: CNT_W] == CntOne) ? '0 : CntOne;
          end
        end
      end
      StRun: begin
        if (n_q < limit_q) begin
          for (int i = 0; i < NDIV; i++) begin
            if ((div_q[i*CNT_W +: CNT_W] != '0) && (res_q[i*CNT_W +: CNT_W] == '0)) begin
              match = 1'b1;
            end
            res_d[i*CNT_W +: CNT_W] =
                (res_q[i*CNT_W +: CNT_W] == (div_q[i*CNT_W +: CNT_W] - CntOne)) ?
                '0 : (res_q[i*CNT_W +: CNT_W] + CntOne);
          end
          if (match) begin
            sum_d = add_full[WIDTH-1:0];
            ovf_d = ovf_q | add_full[WIDTH];
          end
          n_d = n_q + CntOne;
        end else begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      limit_q <= '0;
      div_q   <= '0;
      res_q   <= '0;
      n_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      div_q   <= div_d;
      res_q   <= res_d;
      n_q     <= n_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == StRun);
      done_q  <= (state_d == StDone);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_p1_multisum.sv
// Directed bench for p1_multisum: default, 16-bit-sum and three-divisor instances.
module tb_p1_multisum;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_ab, start_c;
  logic [15:0] limit;
  logic [31:0] div_ab;
  logic [47:0] div_c;

  logic        busy_a, done_a, ovf_a;
  logic [31:0] sum_a;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] sum_b;
  logic        busy_c, done_c, ovf_c;
  logic [31:0] sum_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit both_high = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ((done_a && busy_a) || (done_b && busy_b) || (done_c && busy_c)) both_high = 1'b1;
  end

  p1_multisum u_dut_a (
    .clk(clk), .reset(reset), .start(start_ab), .limit(limit), .div(div_ab),
    .busy(busy_a), .done(done_a), .sum(sum_a), .overflow(ovf_a)
  );

  p1_multisum #(.WIDTH(16)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_ab), .limit(limit), .div(div_ab),
    .busy(busy_b), .done(done_b), .sum(sum_b), .overflow(ovf_b)
  );

  p1_multisum #(.NDIV(3)) u_dut_c (
    .clk(clk), .reset(reset), .start(start_c), .limit(limit), .div(div_c),
    .busy(busy_c), .done(done_c), .sum(sum_c), .overflow(ovf_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_ab_run(input logic [15:0] lim, input logic [31:0] dv);
    @(negedge clk);
    limit    = lim;
    div_ab   = dv;
    start_ab = 1'b1;
    @(negedge clk);
    start_ab = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_ab(input string tag, input int exp_lat, input logic [31:0] exp_sa,
                         input logic [15:0] exp_sb, input logic exp_ob);
    int guard = 0;
    bit busy_ok = 1'b1;
    while (!done_a && guard < 5000) begin
      if (!busy_a) busy_ok = 1'b0;
      @(negedge clk);
      guard++;
    end
    check({tag, " done_a"}, done_a, 1'b1);
    check({tag, " busy_during_run"}, busy_ok, 1'b1);
    check({tag, " latency"}, cyc - acc_cyc, exp_lat);
    check({tag, " busy_at_done"}, busy_a, 1'b0);
    check({tag, " sum_a"}, sum_a, exp_sa);
    check({tag, " ovf_a"}, ovf_a, 1'b0);
    check({tag, " done_b"}, done_b, 1'b1);
    check({tag, " sum_b"}, sum_b, exp_sb);
    check({tag, " ovf_b"}, ovf_b, exp_ob);
  endtask

  task automatic wait_c(input string tag);
    int guard = 0;
    while (!done_c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " done_c"}, done_c, 1'b1);
  endtask

  initial begin
    int t0;
    reset    = 1'b0;
    start_ab = 1'b0;
    start_c  = 1'b0;
    limit    = '0;
    div_ab   = '0;
    div_c    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", busy_a, 1'b0);
    check("rst done", done_a, 1'b0);
    check("rst sum", sum_a, 0);
    check("rst ovf", ovf_a, 1'b0);
    reset = 1'b1;

    start_ab_run(16'd1000, {16'd5, 16'd3});
    wait_ab("l1000", 1000, 32'd233168, 16'd36560, 1'b1);
    repeat (3) @(negedge clk);
    check("done held", done_a, 1'b1);
    check("sum held", sum_a, 32'd233168);

    start_ab_run(16'd10, {16'd5, 16'd3});
    wait_ab("l10", 10, 32'd23, 16'd23, 1'b0);
    start_ab_run(16'd0, {16'd5, 16'd3});
    wait_ab("l0", 1, 32'd0, 16'd0, 1'b0);
    start_ab_run(16'd1, {16'd5, 16'd3});
    wait_ab("l1", 1, 32'd0, 16'd0, 1'b0);
    start_ab_run(16'd50, {16'd0, 16'd0});
    wait_ab("div00", 50, 32'd0, 16'd0, 1'b0);
    start_ab_run(16'd100, {16'd1, 16'd7});
    wait_ab("div17", 100, 32'd4950, 16'd4950, 1'b0);

    // Mid-run start with different operands must be ignored.
    start_ab_run(16'd1000, {16'd5, 16'd3});
    repeat (100) @(negedge clk);
    limit    = 16'd10;
    div_ab   = '0;
    start_ab = 1'b1;
    @(negedge clk);
    start_ab = 1'b0;
    check("ignored busy", busy_a, 1'b1);
    wait_ab("ignored", 1000, 32'd233168, 16'd36560, 1'b1);

    // Reset in the middle of a run.
    start_ab_run(16'd1000, {16'd5, 16'd3});
    while (cyc - acc_cyc < 300) @(negedge clk);
    check("pre-rst sum nonzero", (sum_a != 0), 1'b1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst busy", busy_a, 1'b0);
    check("midrst done", done_a, 1'b0);
    check("midrst sum", sum_a, 0);
    check("midrst ovf", ovf_a, 1'b0);
    check("midrst ovf_b", ovf_b, 1'b0);
    start_ab_run(16'd10, {16'd5, 16'd3});
    wait_ab("postrst", 10, 32'd23, 16'd23, 1'b0);

    // Three divisors, limit 100: 1683+950+735-315-210-105 = 2738. Start held for re-runs.
    @(negedge clk);
    limit   = 16'd100;
    div_c   = {16'd7, 16'd5, 16'd3};
    start_c = 1'b1;
    wait_c("c run1");
    check("c sum1", sum_c, 32'd2738);
    check("c ovf1", ovf_c, 1'b0);
    t0 = cyc;
    @(negedge clk);
    check("c done one cycle", done_c, 1'b0);
    check("c busy rerun", busy_c, 1'b1);
    wait_c("c run2");
    check("c rerun period", cyc - t0, 101);
    check("c sum2", sum_c, 32'd2738);
    start_c = 1'b0;
    @(negedge clk);
    check("c done stays", done_c, 1'b1);

    check("done&busy exclusive", both_high, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
